// File: rtl/dmem_mmio_ctrl_pkg.sv
// Shared constants and address decode for the data-memory / MMIO controller.
package dmem_mmio_ctrl_pkg;

   // Region bases, matched against addr_dmem[31:16]
   localparam logic [15:0] RAM_BASE  = 16'h1001;
   localparam logic [15:0] MMIO_BASE = 16'h1002;

   // MMIO word offsets, matched against addr_dmem[7:2]
   localparam logic [5:0] OFF_LED         = 6'h00;  // byte offset 0x00
   localparam logic [5:0] OFF_CYCLE       = 6'h01;  // byte offset 0x04
   localparam logic [5:0] OFF_FIFO_DATA   = 6'h02;  // byte offset 0x08
   localparam logic [5:0] OFF_FIFO_STATUS = 6'h03;  // byte offset 0x0C

   // FIFO_STATUS bit positions
   localparam int ST_FULL    = 0;
   localparam int ST_EMPTY   = 1;
   localparam int ST_OVF     = 2;
   localparam int ST_CNT_LSB = 4;
   localparam int ST_CNT_MSB = 7;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_RAM,
      SEL_LED,
      SEL_CYCLE,
      SEL_FIFO_DATA,
      SEL_FIFO_STATUS
   } sel_e;

   // Word address decode; the byte-lane bits never reach this function.
   function automatic sel_e decode(input logic [31:2] a);
      sel_e s;
      s = SEL_NONE;
      if (a[31:16] == RAM_BASE) begin
         s = SEL_RAM;
      end else if (a[31:16] == MMIO_BASE && a[15:8] == 8'h00) begin
         case (a[7:2])
            OFF_LED:         s = SEL_LED;
            OFF_CYCLE:       s = SEL_CYCLE;
            OFF_FIFO_DATA:   s = SEL_FIFO_DATA;
            OFF_FIFO_STATUS: s = SEL_FIFO_STATUS;
            default:         s = SEL_NONE;
         endcase
      end
      return s;
   endfunction

endpackage

// File: rtl/dmem_mmio_ctrl_io_fifo.sv
// Output FIFO for the MMIO block: power-of-two depth, 32-bit words.
// A push while full is accepted only if a pop frees a slot in the same cycle.
module io_fifo #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  logic [31:0]                   push_data,
   input  logic                          pop,
   output logic [31:0]                   head,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]   mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(FIFO_DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = empty ? 32'h0 : mem[rd_ptr];

   // Storage is not reset; emptiness is tracked by count alone.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dmem_mmio_ctrl.sv
// CPU data-memory port: word RAM at 0x1001_xxxx, LED / cycle counter /
// output FIFO registers at 0x1002_00xx.
module dmem_mmio_ctrl
   import dmem_mmio_ctrl_pkg::*;
#(
   parameter int RAM_WORDS  = 1024,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr_dmem,
   input  logic [31:0] wdata,
   input  logic        DM_CS,
   input  logic        DM_R,
   input  logic        DM_W,
   output logic [31:0] rdata,
   output logic [31:0] io_data,
   output logic        io_valid,
   input  logic        io_ready,
   output logic [15:0] led
);

   localparam int AW = $clog2(RAM_WORDS);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]   ram [RAM_WORDS];
   logic [AW-1:0] ram_idx;
   sel_e          sel;
   logic          rd_en;
   logic          wr_en;
   logic [31:0]   cycle_q;
   logic          ovf_q;
   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [31:0]   status;
   wire           unused_byte_lane = ^addr_dmem[1:0];

   assign sel     = decode(addr_dmem[31:2]);
   assign ram_idx = addr_dmem[AW+1:2];
   assign rd_en   = DM_CS & DM_R;
   // A store in a cycle where reset is high never commits.
   assign wr_en   = DM_CS & DM_W & ~reset;

   assign fifo_push = wr_en & (sel == SEL_FIFO_DATA);
   assign fifo_pop  = io_valid & io_ready;
   assign io_valid  = ~fifo_empty;

   io_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (wdata),
      .pop       (fifo_pop),
      .head      (io_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // RAM store; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en && sel == SEL_RAM) ram[ram_idx] <= wdata;
   end

   // LED, free-running cycle counter and sticky overflow (set wins over clear).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led     <= '0;
         cycle_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         cycle_q <= cycle_q + 32'd1;
         if (wr_en && sel == SEL_LED) led <= wdata[15:0];
         if (fifo_push && fifo_full && !fifo_pop) ovf_q <= 1'b1;
         else if (wr_en && sel == SEL_FIFO_STATUS) ovf_q <= 1'b0;
      end
   end

   // Status word assembly.
   always_comb begin
      status = '0;
      status[ST_FULL]  = fifo_full;
      status[ST_EMPTY] = fifo_empty;
      status[ST_OVF]   = ovf_q;
      status[ST_CNT_MSB:ST_CNT_LSB] = 4'(fifo_count);
   end

   // Combinational load mux; zero when not reading.
   always_comb begin
      rdata = 32'h0;
      if (rd_en) begin
         case (sel)
            SEL_RAM:         rdata = ram[ram_idx];
            SEL_LED:         rdata = {16'h0, led};
            SEL_CYCLE:       rdata = cycle_q;
            SEL_FIFO_STATUS: rdata = status;
            default:         rdata = 32'h0;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_mmio_ctrl.sv
// Directed bench with a scoreboard: the driver queues expected load data and
// expected FIFO output words; a monitor compares on every read and handshake.
module tb_dmem_mmio_ctrl;

   localparam logic [31:0] A_LED    = 32'h1002_0000;
   localparam logic [31:0] A_CYCLE  = 32'h1002_0004;
   localparam logic [31:0] A_FDATA  = 32'h1002_0008;
   localparam logic [31:0] A_STATUS = 32'h1002_000C;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr_dmem;
   logic [31:0] wdata;
   logic        DM_CS;
   logic        DM_R;
   logic        DM_W;
   logic [31:0] rdata;
   logic [31:0] io_data;
   logic        io_valid;
   logic        io_ready;
   logic [15:0] led;

   typedef struct {
      logic [31:0] v;
      string       name;
      bit          known_only;
   } exp_t;

   exp_t rd_q[$];
   exp_t io_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   dmem_mmio_ctrl #(.RAM_WORDS(1024), .FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .addr_dmem (addr_dmem),
      .wdata     (wdata),
      .DM_CS     (DM_CS),
      .DM_R      (DM_R),
      .DM_W      (DM_W),
      .rdata     (rdata),
      .io_data   (io_data),
      .io_valid  (io_valid),
      .io_ready  (io_ready),
      .led       (led)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr_dmem = a; wdata = d; DM_CS = 1'b1; DM_W = 1'b1; DM_R = 1'b0;
      cyc();
      DM_CS = 1'b0; DM_W = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n, input bit ko = 1'b0);
      exp_t x;
      x.v = e; x.name = n; x.known_only = ko;
      rd_q.push_back(x);
      addr_dmem = a; DM_CS = 1'b1; DM_R = 1'b1; DM_W = 1'b0;
      cyc();
      DM_CS = 1'b0; DM_R = 1'b0;
   endtask

   task automatic push_word(input logic [31:0] d, input bit accepted);
      exp_t x;
      if (accepted) begin
         x.v = d; x.name = "io_data"; x.known_only = 1'b0;
         io_q.push_back(x);
      end
      wr(A_FDATA, d);
   endtask

   // Monitor: compare loads and FIFO handshakes away from the rising edge.
   always @(negedge clk) begin
      exp_t e;
      bit   ok;
      if (DM_CS && DM_R) begin
         n_tests++;
         if (rd_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_read: got 0x%08h expected none", rdata);
         end else begin
            e  = rd_q.pop_front();
            ok = e.known_only ? !$isunknown(rdata) : (rdata === e.v);
            if (!ok) begin
               n_fail++;
               $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, rdata, e.v);
            end
         end
      end
      if (io_valid && io_ready) begin
         n_tests++;
         if (io_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_io: got 0x%08h expected none", io_data);
         end else begin
            e = io_q.pop_front();
            if (io_data !== e.v) begin
               n_fail++;
               $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, io_data, e.v);
            end
         end
      end
   end

   initial begin
      int budget;
      reset = 1'b1; addr_dmem = '0; wdata = '0;
      DM_CS = 1'b0; DM_R = 1'b0; DM_W = 1'b0; io_ready = 1'b0;
      repeat (2) cyc();
      chk("rst_led", {16'h0, led}, 32'h0);
      chk("rst_io_valid", {31'h0, io_valid}, 32'h0);
      chk("rst_io_data", io_data, 32'h0);
      reset = 1'b0;
      cyc();

      // RAM store/load, aliasing, same-cycle read/write, unwritten word
      wr(32'h1001_0010, 32'hDEAD_BEEF);
      rd(32'h1001_0010, 32'hDEAD_BEEF, "ram_rd");
      rd(32'h1001_1012, 32'hDEAD_BEEF, "ram_alias");
      addr_dmem = 32'h1001_0010; wdata = 32'h1234_5678;
      begin
         exp_t x;
         x.v = 32'hDEAD_BEEF; x.name = "ram_rw_old"; x.known_only = 1'b0;
         rd_q.push_back(x);
      end
      DM_CS = 1'b1; DM_R = 1'b1; DM_W = 1'b1;
      cyc();
      DM_CS = 1'b0; DM_R = 1'b0; DM_W = 1'b0;
      rd(32'h1001_0010, 32'h1234_5678, "ram_rw_new");
      rd(32'h1001_0014, 32'h0, "ram_unwritten_known", 1'b1);

      // LED register
      wr(A_LED, 32'h0001_ABCD);
      chk("led_store", {16'h0, led}, 32'h0000_ABCD);
      rd(A_LED, 32'h0000_ABCD, "led_rd");

      // Async reset mid-operation: queued word lost, concurrent store dropped
      push_word(32'h7, 1'b1);
      chk("io_valid_one", {31'h0, io_valid}, 32'h1);
      io_q.delete();
      addr_dmem = A_LED; wdata = 32'h0000_1234; DM_CS = 1'b1; DM_W = 1'b1;
      #1 reset = 1'b1;
      #1;
      chk("rst_async_led", {16'h0, led}, 32'h0);
      chk("rst_async_valid", {31'h0, io_valid}, 32'h0);
      chk("rst_async_data", io_data, 32'h0);
      cyc();
      DM_CS = 1'b0; DM_W = 1'b0;
      reset = 1'b0;

      // Cycle counter from release, forced wrap, read-only store
      repeat (10) cyc();
      chk("rst_store_dropped", {16'h0, led}, 32'h0);
      rd(A_CYCLE, 32'd10, "cycle_10");
      force dut.cycle_q = 32'hFFFF_FFFF;
      #1 release dut.cycle_q;
      rd(A_CYCLE, 32'hFFFF_FFFF, "cycle_max");
      rd(A_CYCLE, 32'h0, "cycle_wrap");
      wr(A_CYCLE, 32'h100);
      rd(A_CYCLE, 32'd2, "cycle_ro");

      // FIFO fill, overflow, drain, clear
      for (int i = 1; i <= 5; i++) push_word(32'(i), i <= 4);
      rd(A_STATUS, 32'h45, "status_full_ovf");
      io_ready = 1'b1;
      repeat (4) cyc();
      chk("drained_valid", {31'h0, io_valid}, 32'h0);
      chk("drained_data", io_data, 32'h0);
      rd(A_STATUS, 32'h06, "status_empty_ovf");
      wr(A_STATUS, 32'h0);
      rd(A_STATUS, 32'h02, "status_cleared");

      // Push into empty with io_ready high: visible the next cycle
      push_word(32'h55, 1'b1);
      chk("empty_push_valid", {31'h0, io_valid}, 32'h1);
      cyc();
      io_ready = 1'b0;

      // Push and pop together while full
      for (int i = 11; i <= 14; i++) push_word(32'(i), 1'b1);
      io_ready = 1'b1;
      push_word(32'h9, 1'b1);
      io_ready = 1'b0;
      rd(A_STATUS, 32'h41, "status_full_pushpop");
      io_ready = 1'b1;
      repeat (4) cyc();
      io_ready = 1'b0;

      // Unmapped / read-only / deselected accesses
      wr(32'h1003_0000, 32'hFFFF_FFFF);
      chk("unmapped_store_led", {16'h0, led}, 32'h0);
      rd(32'h1003_0000, 32'h0, "unmapped_rd");
      rd(A_FDATA, 32'h0, "fifo_data_rd");
      chk("unmapped_store_fifo", {31'h0, io_valid}, 32'h0);
      addr_dmem = A_LED; DM_R = 1'b1; DM_CS = 1'b0;
      #1 chk("no_cs_rd", rdata, 32'h0);
      DM_R = 1'b0;
      wr(A_LED, 32'h0000_5A5A);
      addr_dmem = A_LED; DM_R = 1'b1; DM_CS = 1'b0;
      #1 chk("no_cs_rd_led_set", rdata, 32'h0);
      DM_R = 1'b0;
      rd(A_LED, 32'h0000_5A5A, "led_rd2");

      // Drain any remaining expectations within a bounded window
      budget = 0;
      io_ready = 1'b1;
      while ((io_q.size() != 0 || rd_q.size() != 0) && budget < 20) begin
         cyc();
         budget++;
      end
      if (io_q.size() != 0 || rd_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", io_q.size() + rd_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
